// File: rtl/bfp_frame_ctrl_if.sv
// Stream and buffer-control bundle for bfp_frame_ctrl.
// The master side is the upstream source together with the buffer and shift-stage consumer.
// The slave side is the frame controller itself.
interface bfp_frame_ctrl_if #(
    parameter int ADDR_W     = 5,
    parameter int I_WIDTH    = 23,
    parameter int DATA_WIDTH = 16
);
    logic                                  in_valid;
    logic                                  in_ready;
    logic [DATA_WIDTH-1:0][I_WIDTH-1:0]    din_re;
    logic [DATA_WIDTH-1:0][I_WIDTH-1:0]    din_im;
    logic                                  wr_en;
    logic [ADDR_W-1:0]                     wr_addr;
    logic                                  rd_en;
    logic [ADDR_W-1:0]                     rd_addr;
    logic [4:0]                            min_cnt;
    logic                                  out_valid;
    logic                                  out_last;

    modport master (
        output in_valid, din_re, din_im,
        input  in_ready, wr_en, wr_addr, rd_en, rd_addr, min_cnt, out_valid, out_last
    );

    modport slave (
        input  in_valid, din_re, din_im,
        output in_ready, wr_en, wr_addr, rd_en, rd_addr, min_cnt, out_valid, out_last
    );
endinterface

// File: rtl/bfp_frame_ctrl.sv
// Block-floating-point frame controller.
// It fills one frame of complex vectors into the external stage buffer and tracks
// the frame-wide minimum redundant-sign-bit count. It then drains the frame back in
// order while holding that count steady on min_cnt.
// Optional feature macro: BFP_EXP_ACC_EN adds the exponent accumulator (exp_acc, exp_clr).
module bfp_frame_ctrl #(
    parameter int FRAME_VECS = 32,
    parameter int ADDR_W     = 5,
    parameter int I_WIDTH    = 23,
    parameter int DATA_WIDTH = 16,
    parameter int LENGTH     = 12
) (
    input  logic                clk,
    input  logic                rstn,
    bfp_frame_ctrl_if.slave     bus,
    input  logic                exp_clr,
    output logic signed [5:0]   frame_exp,
    output logic signed [9:0]   exp_acc,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_VECS - 1);
    localparam logic signed [5:0] LEN_S     = 6'(LENGTH);

    state_t            state;
    logic [ADDR_W-1:0] vec_cnt;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [4:0]        scan_min;
    logic [4:0]        min_cnt_q;
    logic [4:0]        beat_min;
    logic [4:0]        next_min;
    logic              accept;
    logic              rd_last;
    logic              valid_d1;
    logic              last_d1;
    logic              out_valid_q;
    logic              out_last_q;

    // Count the bits directly below the MSB that repeat the sign bit.
    function automatic logic [4:0] lead_sign(input logic [I_WIDTH-1:0] x);
        logic [4:0] cnt;
        logic       run;
        cnt = '0;
        run = 1'b1;
        for (int i = I_WIDTH - 2; i >= 0; i--) begin
            if (run && (x[i] == x[I_WIDTH-1]))
                cnt = cnt + 5'd1;
            else
                run = 1'b0;
        end
        return cnt;
    endfunction

    assign accept       = bus.in_valid && (state != DRAIN);
    assign bus.in_ready = (state != DRAIN);
    assign bus.wr_en    = accept;
    assign bus.wr_addr  = vec_cnt;
    assign bus.rd_en    = (state == DRAIN);
    assign bus.rd_addr  = rd_addr_q;
    assign bus.min_cnt  = min_cnt_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign busy         = (state != IDLE);
    assign rd_last      = (state == DRAIN) && (rd_addr_q == LAST_ADDR);

    // Minimum sign count over every re/im sample of the beat, then merge with the running frame minimum.
    // The first beat of a frame (taken in IDLE) seeds the running minimum on its own.
    always_comb begin
        beat_min = 5'd31;
        for (int l = 0; l < DATA_WIDTH; l++) begin
            if (lead_sign(bus.din_re[l]) < beat_min) beat_min = lead_sign(bus.din_re[l]);
            if (lead_sign(bus.din_im[l]) < beat_min) beat_min = lead_sign(bus.din_im[l]);
        end
        if (state == IDLE)
            next_min = beat_min;
        else
            next_min = (beat_min < scan_min) ? beat_min : scan_min;
    end

    // Frame sequencing: fill addresses on accepted beats, latch min_cnt/frame_exp on the last beat, then drain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            vec_cnt   <= '0;
            rd_addr_q <= '0;
            scan_min  <= 5'd31;
            min_cnt_q <= '0;
            frame_exp <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        scan_min <= next_min;
                        vec_cnt  <= ADDR_W'(1);
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        scan_min <= next_min;
                        if (vec_cnt == LAST_ADDR) begin
                            vec_cnt   <= '0;
                            min_cnt_q <= next_min;
                            frame_exp <= LEN_S - $signed({1'b0, next_min});
                            state     <= DRAIN;
                        end else begin
                            vec_cnt <= vec_cnt + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_addr_q <= '0;
                        state     <= IDLE;
                    end else begin
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage delay so valid/last line up with the buffer read plus the shift-stage register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_d1    <= 1'b0;
            last_d1     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            valid_d1    <= bus.rd_en;
            last_d1     <= rd_last;
            out_valid_q <= valid_d1;
            out_last_q  <= last_d1;
        end
    end

`ifdef BFP_EXP_ACC_EN
    // Accumulate the frame exponent as the frame's last output leaves; a clear in that cycle takes priority.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            exp_acc <= '0;
        else if (exp_clr)
            exp_acc <= '0;
        else if (out_last_q)
            exp_acc <= exp_acc + $signed({{4{frame_exp[5]}}, frame_exp});
    end
`else
    logic unused_exp_clr;
    assign unused_exp_clr = exp_clr;
    assign exp_acc        = '0;
`endif

endmodule

// File: tb/tb_bfp_frame_ctrl.sv
// Directed, table-driven bench for bfp_frame_ctrl.
// Each table row describes one frame and the hand-computed min_cnt/frame_exp for it.
// Every cycle is checked against the expected fill/drain/tail timing.
module tb_bfp_frame_ctrl;
    localparam int FRAME_VECS = 32;
    localparam int ADDR_W     = 5;
    localparam int I_WIDTH    = 23;
    localparam int DATA_WIDTH = 16;
    localparam int LENGTH     = 12;

    typedef struct {
        string             name;
        logic [I_WIDTH-1:0] base;
        int                spec_vec;
        int                spec_lane;
        bit                spec_im;
        logic [I_WIDTH-1:0] spec_val;
        bit                gaps;
        bit                hold;
        int                pre_idle;
        bit                clr;
        int                exp_min;
        int                exp_fe;
    } frame_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              exp_clr = 1'b0;
    logic signed [5:0] frame_exp;
    logic signed [9:0] exp_acc;
    logic              busy;

    frame_t frames [9];
    int     checks = 0;
    int     errors = 0;
    int     tail = 0;
    int     prev_min = 0;
    int     prev_fe = 0;
    int     acc_model = 0;
    bit     clr_pending = 1'b0;
    string  cur_tag = "reset";

    bfp_frame_ctrl_if #(.ADDR_W(ADDR_W), .I_WIDTH(I_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    bfp_frame_ctrl #(
        .FRAME_VECS(FRAME_VECS), .ADDR_W(ADDR_W), .I_WIDTH(I_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .LENGTH(LENGTH)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus), .exp_clr(exp_clr),
        .frame_exp(frame_exp), .exp_acc(exp_acc), .busy(busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s (%s): got %0d, expected %0d", name, cur_tag, actual, expected);
        end
    endtask

    // Garbage with zero sign bits; must never reach the minimum because it is never accepted.
    task automatic driveGarbage();
        for (int l = 0; l < DATA_WIDTH; l++) begin
            bus.din_re[l] = 23'h400000;
            bus.din_im[l] = 23'h400000;
        end
    endtask

    task automatic driveBeat(input int f, input int v);
        for (int l = 0; l < DATA_WIDTH; l++) begin
            bus.din_re[l] = frames[f].base;
            bus.din_im[l] = -frames[f].base;
            if (v == frames[f].spec_vec && l == frames[f].spec_lane) begin
                if (frames[f].spec_im) bus.din_im[l] = frames[f].spec_val;
                else                   bus.din_re[l] = frames[f].spec_val;
            end
        end
    endtask

    task automatic checkCycle(input bit e_ready, input bit e_wr, input int e_waddr,
                              input bit e_rd, input int e_raddr, input bit e_busy,
                              input bit e_ov, input bit e_ol, input int e_min, input int e_fe);
        #1;
        checkOutput("in_ready", int'(bus.in_ready), int'(e_ready));
        checkOutput("wr_en", int'(bus.wr_en), int'(e_wr));
        if (e_wr) checkOutput("wr_addr", int'(bus.wr_addr), e_waddr);
        checkOutput("rd_en", int'(bus.rd_en), int'(e_rd));
        if (e_rd) checkOutput("rd_addr", int'(bus.rd_addr), e_raddr);
        checkOutput("busy", int'(busy), int'(e_busy));
        checkOutput("out_valid", int'(bus.out_valid), int'(e_ov));
        checkOutput("out_last", int'(bus.out_last), int'(e_ol));
        checkOutput("min_cnt", int'(bus.min_cnt), e_min);
        checkOutput("frame_exp", int'(frame_exp), e_fe);
        checkOutput("exp_acc", int'(exp_acc), acc_model);
`ifdef BFP_EXP_ACC_EN
        if (exp_clr)   acc_model = 0;
        else if (e_ol) acc_model += prev_fe;
`endif
    endtask

    task automatic nonDrainCycle(input bit e_wr, input int e_waddr, input bit e_busy);
        exp_clr = clr_pending && (tail == 1);
        checkCycle(1'b1, e_wr, e_waddr, 1'b0, 0, e_busy, tail > 0, tail == 1, prev_min, prev_fe);
        if (tail > 0) tail--;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        bus.in_valid = 1'b0;
        driveGarbage();
        for (int i = 0; i < n; i++) nonDrainCycle(1'b0, 0, 1'b0);
    endtask

    // Feed nbeats of frame f (with optional gaps); a full frame is followed by a checked drain.
    task automatic applyStimulus(input int f, input int nbeats);
        cur_tag = frames[f].name;
        for (int k = 0; k < nbeats; k++) begin
            if (frames[f].gaps && k > 0) begin
                int ngap;
                ngap = $urandom_range(0, 2);
                for (int g = 0; g < ngap; g++) begin
                    bus.in_valid = 1'b0;
                    driveGarbage();
                    nonDrainCycle(1'b0, 0, 1'b1);
                end
            end
            bus.in_valid = 1'b1;
            driveBeat(f, k);
            nonDrainCycle(1'b1, k, k != 0);
        end
        if (nbeats == FRAME_VECS) begin
            exp_clr = 1'b0;
            for (int c = 1; c <= FRAME_VECS; c++) begin
                bus.in_valid = frames[f].hold;
                driveGarbage();
                checkCycle(1'b0, 1'b0, 0, 1'b1, c - 1, 1'b1, c >= 3, 1'b0,
                           frames[f].exp_min, frames[f].exp_fe);
                @(posedge clk);
                @(negedge clk);
            end
            bus.in_valid = 1'b0;
            prev_min    = frames[f].exp_min;
            prev_fe     = frames[f].exp_fe;
            tail        = 2;
            clr_pending = frames[f].clr;
        end
    endtask

    task automatic resetCheck();
        #1;
        checkOutput("rst_in_ready", int'(bus.in_ready), 1);
        checkOutput("rst_wr_en", int'(bus.wr_en), 0);
        checkOutput("rst_wr_addr", int'(bus.wr_addr), 0);
        checkOutput("rst_rd_en", int'(bus.rd_en), 0);
        checkOutput("rst_rd_addr", int'(bus.rd_addr), 0);
        checkOutput("rst_min_cnt", int'(bus.min_cnt), 0);
        checkOutput("rst_frame_exp", int'(frame_exp), 0);
        checkOutput("rst_exp_acc", int'(exp_acc), 0);
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_out_last", int'(bus.out_last), 0);
        checkOutput("rst_busy", int'(busy), 0);
    endtask

    initial begin
        //            name       base        svec slane im  sval        gaps hold pre clr  min fe
        frames[0] = '{"single",  23'h000400, 17,  5,    1,  23'h1FFFFF, 0,   0,   2,  0,   1,  11};
        frames[1] = '{"zeros",   23'h000000, -1,  0,    0,  23'h000000, 0,   0,   2,  0,   22, -10};
        frames[2] = '{"lastmin", 23'h000800, 31,  0,    0,  23'h040000, 0,   0,   2,  0,   3,  9};
        frames[3] = '{"gap5",    23'h000800, 5,   7,    0,  23'h010000, 1,   1,   2,  0,   5,  7};
        frames[4] = '{"b2b8",    23'h000800, 0,   15,   1,  23'h7FC000, 1,   1,   0,  0,   8,  4};
        frames[5] = '{"post10",  23'h000800, -1,  0,    0,  23'h000000, 0,   0,   2,  0,   10, 2};
        frames[6] = '{"exp_m3",  23'h000040, -1,  0,    0,  23'h000000, 0,   0,   2,  0,   15, -3};
        frames[7] = '{"exp_p4",  23'h002000, -1,  0,    0,  23'h000000, 0,   0,   2,  0,   8,  4};
        frames[8] = '{"clr",     23'h000800, -1,  0,    0,  23'h000000, 0,   0,   2,  1,   10, 2};

        bus.in_valid = 1'b0;
        driveGarbage();
        rstn = 1'b0;
        @(negedge clk);
        resetCheck();
        @(negedge clk);
        rstn = 1'b1;

        for (int f = 0; f <= 4; f++) begin
            idleCycles(frames[f].pre_idle);
            applyStimulus(f, FRAME_VECS);
        end
        idleCycles(3);

        // Abort a frame after 10 beats (including a min-5 beat); the next frame must not inherit it.
        applyStimulus(3, 10);
        cur_tag = "midreset";
        bus.in_valid = 1'b0;
        exp_clr = 1'b0;
        rstn = 1'b0;
        resetCheck();
        @(negedge clk);
        rstn = 1'b1;
        tail = 0;
        prev_min = 0;
        prev_fe = 0;
        acc_model = 0;
        clr_pending = 1'b0;

        for (int f = 5; f <= 8; f++) begin
            idleCycles(frames[f].pre_idle);
            applyStimulus(f, FRAME_VECS);
        end
        cur_tag = "flush";
        idleCycles(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
